// File: rtl/uart_pkg.sv
// Shared definitions for the UART cores.
// Contents: parity mode constants, the receive FSM state type, and a width
// helper used to size counters and bit indices.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DELIVER,
        ST_BREAK
    } rx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side word interface between the UART receiver and its consumer.
// Signals:
//   rx_data     received word, stable while rx_valid=1
//   rx_valid    word available
//   rx_ready    consumer accepts word
//   parity_err  parity mismatch for the word on rx_data
//   frame_err   stop bit sampled low for the word on rx_data
//   overrun_err one-cycle pulse, a frame was dropped because the word was held
// master = receiver side, slave = consumer side.
interface uart_rx_core_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing.
// Ports:
//   sys_clk, sys_rst_n  clock, async active-low reset
//   load, load_val      reload the counter with load_val (takes priority)
//   tick                high while the counter sits at zero
// The counter parks at zero until reloaded, so tick stays high until the
// owner reacts to it.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int W            = cnt_w(CLKS_PER_BIT)
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receive engine.
// Ports:
//   sys_clk, sys_rst_n  clock, async active-low reset
//   uart_rxd            asynchronous serial input, idles high
//   busy                high whenever the FSM is not in IDLE
//   rx                  word interface (data, valid/ready, error flags)
// Start bit is re-checked at its centre to reject glitches; every later bit
// is sampled one bit period after the previous sample.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             uart_rxd,
    output logic             busy,
    uart_rx_core_if.master   rx
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int IW = cnt_w(DATA_BITS);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic          PAR_ODD   = (PARITY_MODE == PARITY_ODD);

    // Synchroniser resets to the idle line level so reset never fakes a start.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs;

    rx_state_e             state_q, state_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  dperr_q, dperr_d;
    logic                  dferr_q, dferr_d;
    logic                  ovr_q, ovr_d;

    logic                  tmr_load;
    logic [CW-1:0]         tmr_val;
    logic                  tmr_tick;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], uart_rxd};
    assign rxs    = sync_q[SYNC_STAGES-1];

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .W(CW)) u_timer (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        dperr_d  = dperr_q;
        dferr_d  = dferr_q;
        ovr_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = FULL_LOAD;

        // Consumer handshake; DELIVER below may re-assert valid this cycle.
        if (valid_q && rx.rx_ready)
            valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d  = ST_START;
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LOAD;
                end
            end
            ST_START: begin
                if (tmr_tick) begin
                    tmr_load = 1'b1;
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (tmr_tick) begin
                    tmr_load = 1'b1;
                    // Shift in at the top so the first (LSB) bit ends at bit 0.
                    shreg_d  = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tmr_tick) begin
                    tmr_load = 1'b1;
                    perr_d   = (^shreg_q) ^ rxs ^ PAR_ODD;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tmr_tick) begin
                    tmr_load = 1'b1;
                    ferr_d   = ferr_q | ~rxs;
                    if (idx_q == IW'(STOP_BITS - 1))
                        state_d = ST_DELIVER;
                    else
                        idx_d = idx_q + 1'b1;
                end
            end
            ST_DELIVER: begin
                tmr_load = 1'b1;
                if (!valid_q || rx.rx_ready) begin
                    data_d  = shreg_q;
                    dperr_d = perr_q;
                    dferr_d = ferr_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                // A line still low here is a break, not a new start bit.
                state_d = rxs ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d  = ST_IDLE;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q  <= '1;
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            dperr_q <= 1'b0;
            dferr_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            dperr_q <= dperr_d;
            dferr_q <= dferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign rx.rx_data     = data_q;
    assign rx.rx_valid    = valid_q;
    assign rx.parity_err  = dperr_q;
    assign rx.frame_err   = dferr_q;
    assign rx.overrun_err = ovr_q;

endmodule
